// File: rtl/frame_cropper_if.sv
// AXI4-Stream bundle shared by the cropper's input and output sides.
interface axi4_stream_if #(
   parameter int TDATA_WIDTH = 32,
   parameter int TID_WIDTH   = 4,
   parameter int TDEST_WIDTH = 4
);
   logic                     tvalid;
   logic                     tready;
   logic [TDATA_WIDTH-1:0]   tdata;
   logic [TDATA_WIDTH/8-1:0] tstrb;
   logic [TDATA_WIDTH/8-1:0] tkeep;
   logic                     tlast;
   logic                     tuser;
   logic [TID_WIDTH-1:0]     tid;
   logic [TDEST_WIDTH-1:0]   tdest;

   modport master (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest, input tready);
   modport slave  (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/frame_cropper.sv
// Strips TOP/BOTTOM/LEFT/RIGHT borders from an AXI4-Stream frame (tuser = SOF, tlast = EOL).
// One output register stage; video_i.tready = !out_valid || video_o.tready, beats move on tvalid && tready.
module frame_cropper #(
   parameter int PX_WIDTH    = 30,
   parameter int FRAME_RES_X = 1924,
   parameter int FRAME_RES_Y = 1084,
   parameter int TOP         = 2,
   parameter int BOTTOM      = 2,
   parameter int LEFT        = 2,
   parameter int RIGHT       = 2,
   parameter int TID_WIDTH   = 4,
   parameter int TDEST_WIDTH = 4,
   parameter int TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   axi4_stream_if.slave  video_i,
   axi4_stream_if.master video_o,
   output logic         frame_err_o
);
   localparam int XW = $clog2(FRAME_RES_X + 1);
   localparam int YW = $clog2(FRAME_RES_Y + 1);
   localparam logic [XW-1:0] X_FIRST = XW'(LEFT);
   localparam logic [XW-1:0] X_KEPT  = XW'(FRAME_RES_X - RIGHT - 1);
   localparam logic [XW-1:0] X_LAST  = XW'(FRAME_RES_X - 1);
   localparam logic [YW-1:0] Y_FIRST = YW'(TOP);
   localparam logic [YW-1:0] Y_KEPT  = YW'(FRAME_RES_Y - BOTTOM - 1);
   localparam logic [YW-1:0] Y_LAST  = YW'(FRAME_RES_Y - 1);

   if ((LEFT + RIGHT >= FRAME_RES_X) || (TOP + BOTTOM >= FRAME_RES_Y)) begin : g_param_check
      $fatal(1, "frame_cropper: crop borders do not fit inside the frame");
   end

   typedef enum logic {WAIT_SOF, ACTIVE} state_t;
   state_t state_q, state_d;

   logic [XW-1:0] x_q, x_d, cx;
   logic [YW-1:0] y_q, y_d, cy;
   logic          ovf_q, ovf_d, err_q, err_d;
   logic          in_rdy, accept, in_frame, keep, frame_end, err_evt;

   logic                   out_valid_q, out_user_q, out_last_q;
   logic [TDATA_WIDTH-1:0] out_data_q;
   logic [TID_WIDTH-1:0]   out_id_q;
   logic [TDEST_WIDTH-1:0] out_dest_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= WAIT_SOF;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept && in_frame) state_d = frame_end ? WAIT_SOF : ACTIVE;
   end

   // A tuser beat is always evaluated at (0,0), whether it starts a frame or resyncs one.
   always_comb begin
      in_rdy    = !out_valid_q || video_o.tready;
      accept    = video_i.tvalid && in_rdy;
      in_frame  = (state_q == ACTIVE) || video_i.tuser;
      cx        = video_i.tuser ? '0 : x_q;
      cy        = video_i.tuser ? '0 : y_q;
      keep      = in_frame && !(ovf_q && !video_i.tuser) &&
                  (cx >= X_FIRST) && (cx <= X_KEPT) && (cy >= Y_FIRST) && (cy <= Y_KEPT);
      frame_end = in_frame && video_i.tlast && (cy == Y_LAST);
      err_evt   = in_frame &&
                  (((state_q == ACTIVE) && video_i.tuser && ((x_q != '0) || (y_q != '0))) ||
                   (video_i.tlast && (cx != X_LAST)) ||
                   (!video_i.tlast && (cx == X_LAST)));
      x_d   = x_q;
      y_d   = y_q;
      ovf_d = ovf_q;
      err_d = err_q;
      if (accept && in_frame) begin
         if (video_i.tlast) begin
            x_d   = '0;
            y_d   = frame_end ? '0 : cy + 1'b1;
            ovf_d = 1'b0;
         end else if (cx == X_LAST) begin
            // Overlong line: park at the last column and drop until tlast arrives.
            x_d   = X_LAST;
            y_d   = cy;
            ovf_d = 1'b1;
         end else begin
            x_d   = cx + 1'b1;
            y_d   = cy;
            ovf_d = 1'b0;
         end
         err_d = (err_q && (state_q == ACTIVE)) || err_evt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         x_q   <= '0;
         y_q   <= '0;
         ovf_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         ovf_q <= ovf_d;
         err_q <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         out_valid_q <= 1'b0;
         out_user_q  <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= '0;
         out_dest_q  <= '0;
      end else if (accept && keep) begin
         out_valid_q <= 1'b1;
         out_user_q  <= (cx == X_FIRST) && (cy == Y_FIRST);
         out_last_q  <= (cx == X_KEPT) || video_i.tlast;
         out_data_q  <= video_i.tdata;
         out_id_q    <= video_i.tid;
         out_dest_q  <= video_i.tdest;
      end else if (video_o.tready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign video_i.tready = in_rdy;
   assign video_o.tvalid = out_valid_q;
   assign video_o.tdata  = out_data_q;
   assign video_o.tuser  = out_user_q;
   assign video_o.tlast  = out_last_q;
   assign video_o.tid    = out_id_q;
   assign video_o.tdest  = out_dest_q;
   assign video_o.tstrb  = '1;
   assign video_o.tkeep  = '1;
   assign frame_err_o    = err_q;
endmodule

// File: tb/tb_frame_cropper.sv
// Bench for frame_cropper on an 8x6 frame cropped by 2 on every side.
module tb_frame_cropper;
   localparam int X = 8, Y = 6, TOP = 2, BOTTOM = 2, LEFT = 2, RIGHT = 2, DW = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic frame_err;
   always #5 clk = ~clk;

   axi4_stream_if #(.TDATA_WIDTH(DW)) vi ();
   axi4_stream_if #(.TDATA_WIDTH(DW)) vo ();

   frame_cropper #(
      .PX_WIDTH(30), .FRAME_RES_X(X), .FRAME_RES_Y(Y),
      .TOP(TOP), .BOTTOM(BOTTOM), .LEFT(LEFT), .RIGHT(RIGHT)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .video_i(vi), .video_o(vo), .frame_err_o(frame_err)
   );

   int checks = 0;
   int errors = 0;
   logic [41:0] exp_q[$];
   int line_len[Y];
   bit stall = 1'b0;
   bit mon_en = 1'b1;
   bit hold_v = 1'b0;
   logic [41:0] held;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Sink: random backpressure when stalling, applied just after each edge.
   initial begin
      vo.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         vo.tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: scoreboard pop on each transfer, hold check while stalled.
   always @(negedge clk) begin
      logic [41:0] cur;
      cur = {vo.tdest, vo.tid, vo.tuser, vo.tlast, vo.tdata};
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v && vo.tvalid) check("stable_while_stalled", cur, held);
         hold_v = 1'b0;
         if (vo.tvalid && vo.tready) begin
            if (mon_en) begin
               check("out_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check("out_beat", cur, exp_q.pop_front());
            end
         end else if (vo.tvalid) begin
            held   = cur;
            hold_v = 1'b1;
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic u, input logic l, input logic [3:0] id);
      int n;
      logic acc;
      vi.tvalid = 1'b1;
      vi.tdata  = d;
      vi.tuser  = u;
      vi.tlast  = l;
      vi.tid    = id;
      vi.tdest  = id ^ 4'hA;
      n   = 0;
      acc = 1'b0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = vi.tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) check("accept_timeout", acc, 1);
      vi.tvalid = 1'b0;
   endtask

   // Expected output from the cropping rule: rows TOP..Y-BOTTOM-1, columns LEFT up to the
   // earlier of the line's real end and X-RIGHT-1; the last emitted beat of a row carries tlast.
   task automatic send_frame(input bit rnd, output bit exp_err);
      int last_kept;
      logic [31:0] d;
      logic [3:0] id;
      exp_err = 1'b0;
      for (int y = 0; y < Y; y++) begin
         if (line_len[y] != X) exp_err = 1'b1;
         last_kept = (line_len[y] - 1 < X - RIGHT - 1) ? line_len[y] - 1 : X - RIGHT - 1;
         for (int x = 0; x < line_len[y]; x++) begin
            d  = rnd ? $urandom : 32'(y * X + x);
            id = 4'($urandom_range(0, 15));
            if (y >= TOP && y <= Y - BOTTOM - 1 && x >= LEFT && x <= last_kept)
               exp_q.push_back({id ^ 4'hA, id, (x == LEFT && y == TOP), (x == last_kept), d});
            send_beat(d, (x == 0 && y == 0), (x == line_len[y] - 1), id);
         end
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   task automatic full_lines();
      for (int y = 0; y < Y; y++) line_len[y] = X;
   endtask

   initial begin
      bit e;
      vi.tvalid = 1'b0; vi.tdata = '0; vi.tuser = 1'b0; vi.tlast = 1'b0;
      vi.tid = '0; vi.tdest = '0; vi.tstrb = '1; vi.tkeep = '1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", vo.tvalid, 0);
      check("rst_tdata", vo.tdata, 0);
      check("rst_tuser", vo.tuser, 0);
      check("rst_tlast", vo.tlast, 0);
      check("rst_err", frame_err, 0);
      check("rst_tready", vi.tready, 1);
      check("tkeep_ones", vo.tkeep, 4'hF);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      full_lines();
      send_frame(0, e); check("err_s1", frame_err, e); drain();

      stall = 1'b1;
      send_frame(0, e); check("err_s2", frame_err, e); drain();
      stall = 1'b0;

      for (int i = 0; i < 5; i++) send_beat($urandom, 1'b0, 1'($urandom_range(0, 1)), 4'h0);
      send_frame(0, e); check("err_s3", frame_err, e); drain();

      line_len[3] = 5;
      send_frame(0, e); check("err_s4_early_eol", frame_err, e); drain();
      full_lines();
      send_frame(0, e); check("err_s4_cleared", frame_err, e); drain();

      mon_en = 1'b0;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < ((y == 2) ? 3 : X); x++)
            send_beat(32'(y * X + x), (x == 0 && y == 0), (x == X - 1), 4'h0);
      check("tvalid_before_rst", vo.tvalid, 1);
      rst_n = 1'b0;
      #1;
      check("tvalid_in_rst", vo.tvalid, 0);
      check("err_in_rst", frame_err, 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q.delete();
      mon_en = 1'b1;
      send_frame(0, e); check("err_s5", frame_err, e); drain();

      send_frame(0, e); check("err_s6_a", frame_err, e);
      send_frame(0, e); check("err_s6_b", frame_err, e); drain();

      stall = 1'b1;
      for (int f = 0; f < 8; f++) begin
         for (int y = 0; y < Y; y++)
            line_len[y] = ($urandom_range(0, 3) != 0) ? X : int'($urandom_range(1, 11));
         send_frame(1, e);
         check("err_rand", frame_err, e);
      end
      drain();
      stall = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
